// File: rtl/axonerve_axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axonerve_axi_mem_pkg
// Shared types and helpers for the Axonerve AXI4 memory responder:
//   - write / read channel state encodings
//   - seed and tap mask of the optional back-pressure LFSR
//   - word_index(): address -> memory word index (byte offset dropped,
//     upper bits masked so the index wraps modulo the memory depth)
// -----------------------------------------------------------------------------
package axonerve_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_t;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // off_w = log2(bytes per word), idx_w = log2(memory depth)
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (addr >> off_w) & mask;
  endfunction

endpackage

// File: rtl/axonerve_axi_mem_ram.sv
// -----------------------------------------------------------------------------
// axonerve_axi_mem_ram
// Byte-enabled simple-dual-port RAM. One write port with per-byte enables,
// one registered read port. A read and a write to the same word in the same
// cycle return the old contents. Contents are never reset.
// Ports:
//   ap_clk  clock
//   we, waddr, wdata, wbe   write port (wbe = one enable per byte lane)
//   re, raddr               read request; rdata updates on the next edge
//   rdata                   registered read data (holds when re = 0)
// -----------------------------------------------------------------------------
module axonerve_axi_mem_ram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4096
) (
  input  logic                     ap_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge ap_clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axonerve_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axonerve_axi_mem_responder
// AXI4 slave memory answering the m00_axi master port of the Axonerve
// wordcount kernel. INCR bursts on AW/W/B and AR/R, channels independent,
// one outstanding burst per direction.
// Ports:
//   ap_clk, ap_rst_n             clock, synchronous active-low reset
//   m00_axi_aw*/w*/b*            write address / data / response channels
//   m00_axi_ar*/r*               read address / data channels
//   protocol_err                 sticky: wlast disagreed with awlen
// Optional build macro AXONERVE_AXI_MEM_STALL_EN: LFSR-driven back-pressure on
// awready/wready/arready and a random delay before each read burst starts.
// -----------------------------------------------------------------------------
module axonerve_axi_mem_responder
  import axonerve_axi_mem_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 64,
  parameter int C_M00_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH          = 4096
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              m00_axi_awvalid,
  output logic                              m00_axi_awready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  input  logic [7:0]                        m00_axi_awlen,
  input  logic                              m00_axi_wvalid,
  output logic                              m00_axi_wready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  input  logic                              m00_axi_wlast,
  output logic                              m00_axi_bvalid,
  input  logic                              m00_axi_bready,
  input  logic                              m00_axi_arvalid,
  output logic                              m00_axi_arready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  input  logic [7:0]                        m00_axi_arlen,
  output logic                              m00_axi_rvalid,
  input  logic                              m00_axi_rready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  output logic                              m00_axi_rlast,
  output logic                              protocol_err
);

  localparam int STRB_W = C_M00_AXI_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(C_MEM_DEPTH);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [IDX_W-1:0] w_idx, r_idx;
  logic [7:0]       w_len, w_cnt, r_len, r_cnt;

  logic awready_r, wready_r, bvalid_r, arready_r, perr_r;
  logic rvalid_p1, rlast_p1;
  logic [C_M00_AXI_DATA_WIDTH-1:0] rd_data_p1;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_beat_last, r_start;
  logic ram_re;
  logic rdy_gate, fetch_hold;

  assign aw_hs       = m00_axi_awvalid && awready_r;
  assign w_hs        = m00_axi_wvalid && wready_r;
  assign b_hs        = bvalid_r && m00_axi_bready;
  assign ar_hs       = m00_axi_arvalid && arready_r;
  assign r_hs        = rvalid_p1 && m00_axi_rready;
  assign w_beat_last = (w_cnt == w_len);
  assign r_start     = (r_state == R_FETCH) && (r_next == R_DATA);

`ifdef AXONERVE_AXI_MEM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) lfsr <= LFSR_SEED;
    else           lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Ready flags are registered, so gate them with the bit that will be
  // lfsr[0] during the cycle they are visible.
  assign rdy_gate   = ~lfsr_fb;
  assign fetch_hold = lfsr[1];
`else
  assign rdy_gate   = 1'b1;
  assign fetch_hold = 1'b0;
`endif

  // State registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_beat_last) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Lookahead read: the next word is fetched on each accepted beat so the
  // RAM output register always holds the beat being presented.
  always_comb begin
    r_next = r_state;
    ram_re = 1'b0;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: begin
        ram_re = 1'b1;
        if (!fetch_hold) r_next = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_p1) r_next = R_IDLE;
          else          ram_re = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Handshake flags registered from the next state
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_p1 <= 1'b0;
      rlast_p1  <= 1'b0;
      perr_r    <= 1'b0;
    end else begin
      awready_r <= (w_next == W_IDLE) && rdy_gate;
      wready_r  <= (w_next == W_DATA) && rdy_gate;
      bvalid_r  <= (w_next == W_RESP);
      arready_r <= (r_next == R_IDLE) && rdy_gate;
      rvalid_p1 <= (r_next == R_DATA);
      if (r_start)   rlast_p1 <= (r_len == 8'd0);
      else if (r_hs) rlast_p1 <= !rlast_p1 && (8'(r_cnt + 8'd1) == r_len);
      if (w_hs && (m00_axi_wlast != w_beat_last)) perr_r <= 1'b1;
    end
  end

  // Burst address / beat counters (data path, not reset)
  always_ff @(posedge ap_clk) begin
    if (aw_hs) begin
      w_idx <= IDX_W'(word_index(64'(m00_axi_awaddr), OFF_W, IDX_W));
      w_len <= m00_axi_awlen;
      w_cnt <= 8'd0;
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
    end

    if (ar_hs) begin
      r_idx <= IDX_W'(word_index(64'(m00_axi_araddr), OFF_W, IDX_W));
      r_len <= m00_axi_arlen;
    end else if (ram_re && (r_next == R_DATA)) begin
      r_idx <= r_idx + 1'b1;
    end

    if (r_start)   r_cnt <= 8'd0;
    else if (r_hs) r_cnt <= r_cnt + 8'd1;
  end

  axonerve_axi_mem_ram #(
    .DATA_W (C_M00_AXI_DATA_WIDTH),
    .DEPTH  (C_MEM_DEPTH)
  ) u_ram (
    .ap_clk (ap_clk),
    .we     (w_hs),
    .waddr  (w_idx),
    .wdata  (m00_axi_wdata),
    .wbe    (m00_axi_wstrb),
    .re     (ram_re),
    .raddr  (r_idx),
    .rdata  (rd_data_p1)
  );

  assign m00_axi_awready = awready_r;
  assign m00_axi_wready  = wready_r;
  assign m00_axi_bvalid  = bvalid_r;
  assign m00_axi_arready = arready_r;
  assign m00_axi_rvalid  = rvalid_p1;
  assign m00_axi_rlast   = rlast_p1;
  // RAM output is not reset; present zero whenever no beat is valid.
  assign m00_axi_rdata   = rvalid_p1 ? rd_data_p1 : '0;
  assign protocol_err    = perr_r;

endmodule

// File: tb/tb_axonerve_axi_mem_responder.sv
module tb_axonerve_axi_mem_responder;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = DW / 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] wbuf [16];
  logic [DW-1:0] rbuf [16];
  logic          rlast_buf [16];

  always #5 ap_clk = ~ap_clk;

  axonerve_axi_mem_responder dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awlen   (awlen),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wlast   (wlast),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rlast   (rlast),
    .protocol_err    (protocol_err)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge; a handshake
  // happens at the rising edge following a negedge where valid && ready.
  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len,
                           input logic [SW-1:0] strb, input int wlast_beat);
    int t;
    @(negedge ap_clk);
    awvalid = 1'b1; awaddr = addr; awlen = len;
    t = 0;
    while (!awready && t < 50) begin @(negedge ap_clk); t++; end
    if (t >= 50) check("aw_timeout", 1'b0, 1'b1);
    @(negedge ap_clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == wlast_beat);
      check("wready_b2b", wready, 1'b1);
      t = 0;
      while (!wready && t < 50) begin @(negedge ap_clk); t++; end
      if (t >= 50) check("w_timeout", 1'b0, 1'b1);
      @(negedge ap_clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_wlast", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge ap_clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
    check("awready_back", awready, 1'b1);
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len);
    int t;
    rready = 1'b1;
    @(negedge ap_clk);
    arvalid = 1'b1; araddr = addr; arlen = len;
    t = 0;
    while (!arready && t < 50) begin @(negedge ap_clk); t++; end
    if (t >= 50) check("ar_timeout", 1'b0, 1'b1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    check("rvalid_n1", rvalid, 1'b0);
    @(negedge ap_clk);
    for (int k = 0; k <= int'(len); k++) begin
      check("rvalid_b2b", rvalid, 1'b1);
      t = 0;
      while (!rvalid && t < 50) begin @(negedge ap_clk); t++; end
      if (t >= 50) check("r_timeout", 1'b0, 1'b1);
      rbuf[k] = rdata;
      rlast_buf[k] = rlast;
      @(negedge ap_clk);
    end
    check("rvalid_done", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [DW-1:0] exp_w;

    // Reset values
    repeat (3) @(negedge ap_clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_perr", protocol_err, 1'b0);
    ap_rst_n = 1'b1;
    check("awready_before_sample", awready, 1'b0);
    @(negedge ap_clk);
    check("awready_after_rst", awready, 1'b1);
    check("arready_after_rst", arready, 1'b1);

    // Single-beat write / read at 0x40
    wbuf[0] = {8{64'h1122334455667788}};
    axi_write(64'h40, 8'd0, '1, 0);
    axi_read(64'h40, 8'd0);
    check("single_data", rbuf[0], {8{64'h1122334455667788}});
    check("single_rlast", rlast_buf[0], 1'b1);
    check("perr_clean", protocol_err, 1'b0);

    // 16-beat burst
    for (int b = 0; b < 16; b++) wbuf[b] = DW'(b);
    axi_write(64'h1000, 8'd15, '1, 15);
    axi_read(64'h1000, 8'd15);
    for (int k = 0; k < 16; k++) begin
      check("burst_data", rbuf[k], DW'(k));
      check("burst_rlast", rlast_buf[k], (k == 15));
    end

    // Partial byte strobes on a word preset to all ones
    wbuf[0] = '1;
    axi_write(64'h2000, 8'd0, '1, 0);
    wbuf[0] = {16{32'h12345678}};
    axi_write(64'h2000, 8'd0, 64'hF, 0);
    axi_read(64'h2000, 8'd0);
    exp_w = {{480{1'b1}}, 32'h12345678};
    check("wstrb_merge", rbuf[0], exp_w);

    // Burst wrapping past the top of memory (high address bits ignored)
    for (int b = 0; b < 4; b++) wbuf[b] = DW'(256 + b);
    axi_write(64'h0000_0001_0003_FF80, 8'd3, '1, 3);
    axi_read(64'h0, 8'd0);
    check("wrap_word0", rbuf[0], DW'(258));
    axi_read(64'h40, 8'd0);
    check("wrap_word1", rbuf[0], DW'(259));
    axi_read(64'h3FF80, 8'd3);
    for (int k = 0; k < 4; k++) check("wrap_read", rbuf[k], DW'(256 + k));

    // Early wlast: sticky error, burst still completes on awlen
    for (int b = 0; b < 4; b++) wbuf[b] = DW'(32'hA0 + b);
    axi_write(64'h8000, 8'd3, '1, 1);
    check("perr_set", protocol_err, 1'b1);
    axi_read(64'h8000, 8'd3);
    check("perr_beat3", rbuf[3], DW'(32'hA3));
    wbuf[0] = DW'(32'h55);
    axi_write(64'h9000, 8'd0, '1, 0);
    check("perr_sticky", protocol_err, 1'b1);

    // Reset in the middle of a read burst
    rready = 1'b1;
    @(negedge ap_clk);
    arvalid = 1'b1; araddr = 64'h1000; arlen = 8'd15;
    t = 0;
    while (!arready && t < 50) begin @(negedge ap_clk); t++; end
    if (t >= 50) check("ar_timeout", 1'b0, 1'b1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("mid_rdata", rdata, DW'(2));
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_arready", arready, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    check("rst_mid_arready_hold", arready, 1'b0);
    @(negedge ap_clk);
    check("rst_mid_arready_back", arready, 1'b1);
    check("rst_mid_perr_clr", protocol_err, 1'b0);
    axi_read(64'h1140, 8'd0);
    check("mem_survives_a", rbuf[0], DW'(5));
    axi_read(64'h40, 8'd0);
    check("mem_survives_b", rbuf[0], DW'(259));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
